// File: rtl/ss_rvc_muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle.
// Shift-add multiply, restoring divide; div-by-zero and signed overflow bypass the iteration.
module ss_rvc_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             QClk,
    input  logic             RstQnnnN,
    input  logic             ReqValidQ102H,
    output logic             ReqReadyQ102H,
    input  logic [2:0]       ReqOpQ102H,
    input  logic [XLEN-1:0]  ReqSrc1Q102H,
    input  logic [XLEN-1:0]  ReqSrc2Q102H,
    input  logic [TAG_W-1:0] ReqTagQ102H,
    input  logic             FlushQnnnH,
    output logic             RspValidQnnnH,
    input  logic             RspReadyQnnnH,
    output logic [XLEN-1:0]  RspDataQnnnH,
    output logic [TAG_W-1:0] RspTagQnnnH,
    output logic             BusyQnnnH
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    // Request decode and operand conditioning
    logic            req_div;
    logic            s1_signed;
    logic            s2_signed;
    logic            s1_neg;
    logic            s2_neg;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            req_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_data;

    always_comb begin
        req_div   = ReqOpQ102H[2];
        s1_signed = (ReqOpQ102H == 3'b001) || (ReqOpQ102H == 3'b010) ||
                    (ReqOpQ102H == 3'b100) || (ReqOpQ102H == 3'b110);
        s2_signed = (ReqOpQ102H == 3'b001) || (ReqOpQ102H == 3'b100) ||
                    (ReqOpQ102H == 3'b110);
        s1_neg    = s1_signed && ReqSrc1Q102H[XLEN-1];
        s2_neg    = s2_signed && ReqSrc2Q102H[XLEN-1];
        mag1      = s1_neg ? -ReqSrc1Q102H : ReqSrc1Q102H;
        mag2      = s2_neg ? -ReqSrc2Q102H : ReqSrc2Q102H;
        // REM follows the dividend sign; everything else follows the operand sign difference
        req_neg   = (ReqOpQ102H == 3'b110) ? s1_neg : (s1_neg ^ s2_neg);
        div_zero  = req_div && (ReqSrc2Q102H == '0);
        div_ovf   = ((ReqOpQ102H == 3'b100) || (ReqOpQ102H == 3'b110)) &&
                    (ReqSrc1Q102H == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (ReqSrc2Q102H == '1);
        if (div_zero)
            fast_data = ReqOpQ102H[1] ? ReqSrc1Q102H : '1;
        else
            fast_data = ReqOpQ102H[1] ? '0 : ReqSrc1Q102H;
    end

    // One iteration: acc = {product high | remainder, multiplier | dividend->quotient}
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod_res;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   result;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_trial = div_shift - {1'b0, addend};
        if (op[2])
            step_next = {(div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0]),
                         acc[XLEN-2:0], ~div_trial[XLEN]};
        else
            step_next = {mul_sum, acc[XLEN-1:1]};
        prod_res = neg ? -step_next : step_next;
        div_val  = op[1] ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
        if (op[2])
            result = neg ? -div_val : div_val;
        else if (op[1:0] == 2'b00)
            result = prod_res[XLEN-1:0];
        else
            result = prod_res[2*XLEN-1:XLEN];
    end

    always_ff @(posedge QClk or negedge RstQnnnN) begin
        if (!RstQnnnN) begin
            state    <= S_IDLE;
            op       <= '0;
            neg      <= 1'b0;
            addend   <= '0;
            acc      <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
        end else if (FlushQnnnH) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ReqValidQ102H) begin
                        op      <= ReqOpQ102H;
                        neg     <= req_neg;
                        cnt     <= '0;
                        rsp_tag <= ReqTagQ102H;
                        if (div_zero || div_ovf) begin
                            rsp_data <= fast_data;
                            state    <= S_DONE;
                        end else begin
                            addend <= req_div ? mag2 : mag1;
                            acc    <= {{XLEN{1'b0}}, (req_div ? mag1 : mag2)};
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= step_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1)) begin
                        rsp_data <= result;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (RspReadyQnnnH)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ReqReadyQ102H = (state == S_IDLE);
    assign BusyQnnnH     = (state != S_IDLE);
    assign RspValidQnnnH = (state == S_DONE);
    assign RspDataQnnnH  = rsp_data;
    assign RspTagQnnnH   = rsp_tag;

endmodule

// File: tb/tb_ss_rvc_muldiv.sv
// Directed bench for ss_rvc_muldiv: vector table plus backpressure, flush and reset sequences.
module tb_ss_rvc_muldiv;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [4:0]  req_tag;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    ss_rvc_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .QClk          (clk),
        .RstQnnnN      (rst_n),
        .ReqValidQ102H (req_valid),
        .ReqReadyQ102H (req_ready),
        .ReqOpQ102H    (req_op),
        .ReqSrc1Q102H  (req_src1),
        .ReqSrc2Q102H  (req_src2),
        .ReqTagQ102H   (req_tag),
        .FlushQnnnH    (flush),
        .RspValidQnnnH (rsp_valid),
        .RspReadyQnnnH (rsp_ready),
        .RspDataQnnnH  (rsp_data),
        .RspTagQnnnH   (rsp_tag),
        .BusyQnnnH     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("req_ready_timeout", 64'd0, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_tag   = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Issue, measure latency from the accept edge, check result, complete handshake.
    task automatic run_vec(input string name, input vec_t v);
        int n;
        bit ready_seen;
        send(v.op, v.a, v.b, v.tag);
        n = 1;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            if (req_ready) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (req_ready) ready_seen = 1'b1;
        check({name, "_latency"}, 64'(n), v.fast ? 64'd1 : 64'd33);
        check({name, "_data"}, 64'(rsp_data), 64'(v.exp));
        check({name, "_tag"}, 64'(rsp_tag), 64'(v.tag));
        check({name, "_ready_low"}, 64'(ready_seen), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({name, "_ready_after"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        logic [31:0] held_data;
        logic [4:0]  held_tag;
        int n;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'h7FFF_FFFC, 1'b0};
        vecs[7]  = '{3'b111, 32'h0000_0007, 32'h0000_0002, 5'd8,  32'h0000_0001, 1'b0};
        vecs[8]  = '{3'b100, 32'h0000_0005, 32'h0000_0000, 5'd9,  32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 5'd10, 32'h0000_0005, 1'b1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1'b1};
        vecs[12] = '{3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 5'd13, 32'hFFFF_FFFF, 1'b0};
        vecs[13] = '{3'b101, 32'd100,       32'd7,         5'd14, 32'd14,        1'b0};
        vecs[14] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         1'b0};
        vecs[15] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        req_tag   = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(rsp_data), 64'd0);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: response must hold for 10 cycles
        rsp_ready = 1'b0;
        send(3'b101, 32'd100, 32'd7, 5'd21);
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 64'(n), 64'd33);
        held_data = rsp_data;
        held_tag  = rsp_tag;
        check("bp_data", 64'(held_data), 64'd14);
        check("bp_tag", 64'(held_tag), 64'd21);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_data", 64'(rsp_data), 64'(held_data));
            check("bp_hold_tag", 64'(rsp_tag), 64'(held_tag));
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
            check("bp_hold_busy", 64'(busy), 64'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req_ready), 64'd1);
        check("bp_release_valid", 64'(rsp_valid), 64'd0);

        // Flush during CALC
        send(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd22);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(req_ready), 64'd1);
        check("flush_valid", 64'(rsp_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        v = '{3'b101, 32'd100, 32'd7, 5'd23, 32'd14, 1'b0};
        run_vec("after_flush", v);

        // Flush wins over a same-cycle request
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        req_op    = 3'b101;
        req_src1  = 32'd50;
        req_src2  = 32'd3;
        req_tag   = 5'd24;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd1);
        check("flush_req_busy", 64'(busy), 64'd0);

        // Reset pulse mid-CALC
        send(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd25);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd1);
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(rsp_data), 64'd0);
        check("midrst_tag", 64'(rsp_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{3'b101, 32'd100, 32'd7, 5'd26, 32'd14, 1'b0};
        run_vec("after_reset", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ss_rvc_muldiv.md
# ss_rvc_muldiv

Iterative, parametrised multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the Q102H ALU. The execute stage hands it forwarded operands plus the destination register tag over a valid/ready request channel. The unit returns the result and tag over a valid/ready response channel after a multi-cycle computation. The unit is stallable via backpressure and flushable.

## Interface
Parameters:
- XLEN, 32, operand/result width; any even value ≥ 8.
- TAG_W, 5, width of the opaque tag (destination register index).

Ports:
- QClk  in  1  core clock; all state changes on rising edge.
- RstQnnnN  in  1  reset, asynchronous, active-low.
- ReqValidQ102H  in  1  request valid.
- ReqReadyQ102H  out  1  unit can accept a request; combinational from state, high only in IDLE.
- ReqOpQ102H  in  3  Funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ReqSrc1Q102H  in  XLEN  rs1 operand (multiplicand / dividend).
- ReqSrc2Q102H  in  XLEN  rs2 operand (multiplier / divisor).
- ReqTagQ102H  in  TAG_W  tag returned with the result.
- FlushQnnnH  in  1  abort any in-flight operation.
- RspValidQnnnH  out  1  result valid.
- RspReadyQnnnH  in  1  consumer accepts the result.
- RspDataQnnnH  out  XLEN  result.
- RspTagQnnnH  out  TAG_W  tag of the result.
- BusyQnnnH  out  1  high when state is not IDLE.

## Operation
- The FSM has three states:
  - IDLE: ReqReady=1. On ReqValid && !Flush, latch the op, tag and operands.
    - On divide-by-zero or signed overflow, go to DONE (fast path).
    - Otherwise go to CALC with the iteration counter cleared.
  - CALC: performs one radix-2 step per cycle for exactly XLEN cycles, then goes to DONE.
  - DONE: RspValid=1. On RspReady, go to IDLE.
- Operand conditioning at accept:
  - Signed operands (MULH both, MULHSU rs1 only, DIV/REM both) are converted to magnitude.
  - A negate flag is recorded for the result.
- Multiply:
  - Shift-add into a 2·XLEN product register.
  - If the negate flag is set, the full 2·XLEN product is two's-complemented.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Divide:
  - Restoring division with an XLEN+1-bit partial remainder.
  - Quotient sign is negative iff the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Fast paths (no CALC):
  - Divisor == 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - DIV/REM with dividend = −2^(XLEN−1) and divisor = −1: DIV returns the dividend; REM returns 0.
- RspData and RspTag are registered and remain stable while RspValid=1 && !RspReady.
- Flush:
  - From any state, the next state is IDLE.
  - RspValid is low the following cycle and the in-flight result is discarded.
  - Flush in the same cycle as ReqValid in IDLE: flush wins and no accept occurs.
- Only one operation is in flight. A new request cannot be accepted in the same cycle as the response handshake.

## Timing
- Reset values (asynchronous, during and after RstQnnnN low):
  - State IDLE, ReqReady=1, RspValid=0, RspData=0, RspTag=0, BusyQnnnH=0, counter=0.
- Cycle numbering: cycle 0 is the accept edge. CALC occupies cycles 1..XLEN. RspValid is first high in cycle XLEN+1 (cycle 33 for XLEN=32).
- Fast path: RspValid is high in cycle 1.
- Minimum issue interval with RspReady tied high:
  - XLEN+2 cycles for the normal path.
  - 2 cycles for the fast path.
- Reset asserted mid-CALC or in DONE: outputs take reset values immediately; no response is produced.
- The counter is log2(XLEN)+1 bits wide and does not wrap. The CALC exit compare is counter == XLEN−1.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), tag 5, RspReady=1: RspValid at cycle 33, RspData=0xFFFFFFEB, RspTag=5, ReqReady=0 for cycles 1..33.
- High multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division signs:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
  - REMU 7/2 → 1.
- Corner cases, each with RspValid at cycle 1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold RspReady=0 for 10 cycles after RspValid.
  - RspData and RspTag stay constant, ReqReady=0, Busy=1.
  - One cycle after the RspReady pulse, ReqReady=1.
- Flush and reset:
  - Assert FlushQnnnH at cycle 10 of a DIVU: RspValid never rises, ReqReady=1 at cycle 11.
  - An immediate DIVU 100/7 then returns 14.
  - Repeat with RstQnnnN pulsed low mid-CALC instead of flush: the same outputs go idle asynchronously.
